// File: rtl/fb_write_packer_if.sv
// Write-word channel from the framebuffer packer to the DDR3 request arbiter.
// The packer is the master (drives valid/addr/data/mask); the arbiter is the
// slave and answers with ready.
interface fb_write_packer_if #(
  parameter int ADDR_BITS = 18,
  parameter int WORD_BITS = 72,
  parameter int MASK_BITS = 4
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic [MASK_BITS-1:0] wr_mask;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_mask,
    output wr_ready
  );
endinterface

// File: rtl/fb_write_packer.sv
// Framebuffer write-side front end: tracks frame position of the renderer pixel
// stream, packs PIX_PER_WORD pixels into one DDR3 write word and queues finished
// words in a small FIFO presented over a valid/ready channel. Never stalls the
// renderer; words that find the FIFO full are dropped and flagged in overflow.
module fb_write_packer #(
  parameter int COLOR_BITS   = 18,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_BITS    = 18,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           fb_width,
  input  logic [9:0]            fb_height,
  input  logic                  fb_vsync,
  input  logic                  fb_we,
  input  logic [COLOR_BITS-1:0] fb_data,
  fb_write_packer_if.master     wr,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int LANE_W = $clog2(PIX_PER_WORD);
  localparam int IDX_W  = ADDR_BITS + LANE_W;
  localparam int WORD_W = PIX_PER_WORD * COLOR_BITS;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]    addr;
    logic [WORD_W-1:0]       data;
    logic [PIX_PER_WORD-1:0] mask;
  } word_t;

  // Control state (async reset)
  state_t                  state_q, state_d;
  logic [10:0]             width_q, width_d;
  logic [9:0]              height_q, height_d;
  logic [10:0]             x_q, x_d;
  logic [9:0]              y_q, y_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PIX_PER_WORD-1:0] pmask_q, pmask_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overflow_q, overflow_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Datapath state (no reset; qualified by pmask / cnt)
  logic [WORD_W-1:0]       pdata_q, pdata_d;
  logic [ADDR_BITS-1:0]    paddr_q, paddr_d;
  word_t                   mem_q [FIFO_DEPTH];
  word_t                   mem_d [FIFO_DEPTH];

  // Push requests from the packer: push_a flushes a partial word on vsync,
  // push_b carries the word completed by the current pixel. Both can occur in
  // one cycle only for a 1x1 frame started while a partial word was pending.
  logic                    push_a, push_b;
  word_t                   word_a, word_b;
  logic [LANE_W-1:0]       lane_c;
  logic                    last_c;

  logic                    pop;
  logic [CNT_W-1:0]        avail;
  logic                    acc_a, acc_b;
  word_t                   head;

  // Frame tracking and pixel packing: vsync actions first, then the pixel.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    pmask_d      = pmask_q;
    pdata_d      = pdata_q;
    paddr_d      = paddr_q;
    frame_done_d = 1'b0;
    push_a       = 1'b0;
    push_b       = 1'b0;
    word_a       = '0;
    word_b       = '0;
    lane_c       = '0;
    last_c       = 1'b0;

    if (fb_vsync) begin
      width_d  = fb_width;
      height_d = fb_height;
      state_d  = ACTIVE;
      if (pmask_q != '0) begin
        push_a = 1'b1;
        word_a = '{addr: paddr_q, data: pdata_q, mask: pmask_q};
      end
      idx_d   = '0;
      x_d     = '0;
      y_d     = '0;
      pmask_d = '0;
    end

    if (fb_we && (state_d == ACTIVE)) begin
      lane_c = idx_d[LANE_W-1:0];
      if (lane_c == '0) begin
        paddr_d = idx_d[IDX_W-1:LANE_W];
        pmask_d = '0;
      end
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        if (lane_c == LANE_W'(i)) begin
          pdata_d[i*COLOR_BITS +: COLOR_BITS] = fb_data;
          pmask_d[i]                          = 1'b1;
        end
      end
      last_c = (x_d == width_d - 11'd1) && (y_d == height_d - 10'd1);
      if ((lane_c == LANE_W'(PIX_PER_WORD - 1)) || last_c) begin
        push_b  = 1'b1;
        word_b  = '{addr: paddr_d, data: pdata_d, mask: pmask_d};
        pmask_d = '0;
      end
      if (last_c) begin
        idx_d        = '0;
        x_d          = '0;
        y_d          = '0;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_d + IDX_W'(1);
        if (x_d == width_d - 11'd1) begin
          x_d = '0;
          y_d = y_d + 10'd1;
        end else begin
          x_d = x_d + 11'd1;
        end
      end
    end
  end

  // FIFO bookkeeping: a pop in the same cycle frees a slot for an incoming push.
  always_comb begin
    pop    = (cnt_q != '0) && wr.wr_ready;
    avail  = CNT_W'(FIFO_DEPTH) - cnt_q + CNT_W'(pop);
    acc_a  = push_a && (avail >= CNT_W'(1));
    acc_b  = push_b && (avail >= (acc_a ? CNT_W'(2) : CNT_W'(1)));
    mem_d  = mem_q;
    if (acc_a) begin
      mem_d[wptr_q] = word_a;
    end
    if (acc_b) begin
      mem_d[acc_a ? (wptr_q + PTR_W'(1)) : wptr_q] = word_b;
    end
    wptr_d     = wptr_q + PTR_W'(acc_a) + PTR_W'(acc_b);
    rptr_d     = rptr_q + PTR_W'(pop);
    cnt_d      = cnt_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(pop);
    overflow_d = overflow_q | (push_a && !acc_a) | (push_b && !acc_b);
  end

  // Control registers; reset discards any partial word and the FIFO contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_VSYNC;
      width_q      <= '0;
      height_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      pmask_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      pmask_q      <= pmask_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Word assembly buffer and FIFO storage.
  always_ff @(posedge clk) begin
    pdata_q <= pdata_d;
    paddr_q <= paddr_d;
    mem_q   <= mem_d;
  end

  // Head presentation is gated by valid so the bus reads zero while empty.
  always_comb begin
    head        = mem_q[rptr_q];
    wr.wr_valid = (cnt_q != '0);
    wr.wr_addr  = wr.wr_valid ? head.addr : '0;
    wr.wr_data  = wr.wr_valid ? head.data : '0;
    wr.wr_mask  = wr.wr_valid ? head.mask : '0;
  end

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fb_write_packer.sv
// Scoreboard bench for fb_write_packer: stimulus pushes hand-computed expected
// words into a queue; a monitor pops and compares on every accepted word and
// checks that a stalled head stays stable.
module tb_fb_write_packer;

  typedef struct {
    logic [17:0] addr;
    logic [71:0] data;
    logic [3:0]  mask;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] fb_width;
  logic [9:0]  fb_height;
  logic        fb_vsync;
  logic        fb_we;
  logic [17:0] fb_data;
  logic        frame_done;
  logic        overflow;

  fb_write_packer_if #(.ADDR_BITS(18), .WORD_BITS(72), .MASK_BITS(4)) wr ();

  fb_write_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fb_width   (fb_width),
    .fb_height  (fb_height),
    .fb_vsync   (fb_vsync),
    .fb_we      (fb_we),
    .fb_data    (fb_data),
    .wr         (wr),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  int   n_vec;
  int   n_err;
  int   fd_cnt;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [71:0] pk(input logic [17:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic expw(input logic [17:0] addr, input logic [71:0] data, input logic [3:0] mask);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic vs, input logic we, input logic [17:0] d);
    fb_vsync = vs;
    fb_we    = we;
    fb_data  = d;
    tick();
    fb_vsync = 1'b0;
    fb_we    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 96'(exp_q.size()), 96'(0));
  endtask

  // Monitor: compares every accepted word and the stability of a stalled head.
  initial begin : monitor
    exp_t        e;
    logic [71:0] m;
    logic        hold_v;
    logic [17:0] hold_addr;
    logic [71:0] hold_data;
    logic [3:0]  hold_mask;
    hold_v    = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    hold_mask = '0;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      if (rst_n !== 1'b1) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", 96'(wr.wr_valid), 96'(1));
          chk("hold_addr", 96'(wr.wr_addr), 96'(hold_addr));
          chk("hold_data", 96'(wr.wr_data), 96'(hold_data));
          chk("hold_mask", 96'(wr.wr_mask), 96'(hold_mask));
        end
        if (wr.wr_valid && wr.wr_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got addr %0h mask %0h expected none",
                     wr.wr_addr, wr.wr_mask);
          end else begin
            e = exp_q.pop_front();
            m = '0;
            for (int i = 0; i < 4; i++) if (e.mask[i]) m[i*18 +: 18] = '1;
            chk("word_addr", 96'(wr.wr_addr), 96'(e.addr));
            chk("word_mask", 96'(wr.wr_mask), 96'(e.mask));
            chk("word_data", 96'(wr.wr_data & m), 96'(e.data & m));
          end
        end
        hold_v    = wr.wr_valid && !wr.wr_ready;
        hold_addr = wr.wr_addr;
        hold_data = wr.wr_data;
        hold_mask = wr.wr_mask;
      end
    end
  end

  initial begin : stim
    int fd0;
    n_vec     = 0;
    n_err     = 0;
    fd_cnt    = 0;
    rst_n     = 1'b0;
    fb_width  = '0;
    fb_height = '0;
    fb_vsync  = 1'b0;
    fb_we     = 1'b0;
    fb_data   = '0;
    wr.wr_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", 96'(wr.wr_valid), 96'(0));
    chk("rst_addr", 96'(wr.wr_addr), 96'(0));
    chk("rst_mask", 96'(wr.wr_mask), 96'(0));
    chk("rst_frame_done", 96'(frame_done), 96'(0));
    chk("rst_overflow", 96'(overflow), 96'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: pixels before any vsync are ignored
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      px(1'b0, 1'b1, 18'(i + 7));
      chk("pre_vsync_valid", 96'(wr.wr_valid), 96'(0));
    end
    tick();
    chk("pre_vsync_frame_done", 96'(fd_cnt - fd0), 96'(0));

    // 2: a complete 16x8 frame, value = index
    fb_width  = 11'd16;
    fb_height = 10'd8;
    px(1'b1, 1'b0, 18'd0);
    fd0 = fd_cnt;
    for (int i = 0; i < 128; i++) begin
      if (i % 4 == 3)
        expw(18'(i / 4), pk(18'(i - 3), 18'(i - 2), 18'(i - 1), 18'(i)), 4'hF);
      px(1'b0, 1'b1, 18'(i));
    end
    drain();
    tick();
    tick();
    chk("full_frame_done_count", 96'(fd_cnt - fd0), 96'(1));
    chk("full_frame_overflow", 96'(overflow), 96'(0));

    // 3: 6x1 frame -> one full word, one partial, frame_done, then wrap
    fb_width  = 11'd6;
    fb_height = 10'd1;
    px(1'b1, 1'b0, 18'd0);
    expw(18'd0, pk(18'd0, 18'd1, 18'd2, 18'd3), 4'hF);
    expw(18'd1, pk(18'd4, 18'd5, 18'd0, 18'd0), 4'h3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("fd_before_last", 96'(frame_done), 96'(0));
      px(1'b0, 1'b1, 18'(i));
    end
    chk("fd_after_last", 96'(frame_done), 96'(1));
    tick();
    chk("fd_one_cycle", 96'(frame_done), 96'(0));
    expw(18'd0, pk(18'd10, 18'd11, 18'd12, 18'd13), 4'hF);
    for (int i = 0; i < 4; i++) px(1'b0, 1'b1, 18'(10 + i));
    drain();

    // 4: vsync after 5 pixels flushes a one-pixel partial word
    fb_width  = 11'd640;
    fb_height = 10'd480;
    px(1'b1, 1'b0, 18'd0);
    expw(18'd0, pk(18'h100, 18'h101, 18'h102, 18'h103), 4'hF);
    expw(18'd1, pk(18'h104, 18'd0, 18'd0, 18'd0), 4'h1);
    for (int i = 0; i < 5; i++) px(1'b0, 1'b1, 18'(18'h100 + i));
    px(1'b1, 1'b0, 18'd0);
    expw(18'd0, pk(18'h200, 18'h201, 18'h202, 18'h203), 4'hF);
    for (int i = 0; i < 4; i++) px(1'b0, 1'b1, 18'(18'h200 + i));
    drain();

    // 6: vsync and pixel in the same cycle with two lanes pending
    px(1'b1, 1'b0, 18'd0);
    expw(18'd0, pk(18'h300, 18'h301, 18'd0, 18'd0), 4'h3);
    expw(18'd0, pk(18'h310, 18'h311, 18'h312, 18'h313), 4'hF);
    px(1'b0, 1'b1, 18'h300);
    px(1'b0, 1'b1, 18'h301);
    px(1'b1, 1'b1, 18'h310);
    for (int i = 1; i < 4; i++) px(1'b0, 1'b1, 18'(18'h310 + i));
    drain();

    // Push into a full FIFO while the head is popped the same cycle
    wr.wr_ready = 1'b0;
    px(1'b1, 1'b0, 18'd0);
    for (int k = 0; k < 9; k++)
      expw(18'(k), pk(18'(18'h400 + 4*k), 18'(18'h401 + 4*k),
                      18'(18'h402 + 4*k), 18'(18'h403 + 4*k)), 4'hF);
    for (int i = 0; i < 35; i++) px(1'b0, 1'b1, 18'(18'h400 + i));
    chk("full_valid", 96'(wr.wr_valid), 96'(1));
    wr.wr_ready = 1'b1;
    px(1'b0, 1'b1, 18'h423);
    drain();
    chk("push_pop_full_overflow", 96'(overflow), 96'(0));

    // 5: stall with 9 words -> 8 held in order, 9th dropped, overflow sticky
    wr.wr_ready = 1'b0;
    px(1'b1, 1'b0, 18'd0);
    for (int k = 0; k < 8; k++)
      expw(18'(k), pk(18'(18'h500 + 4*k), 18'(18'h501 + 4*k),
                      18'(18'h502 + 4*k), 18'(18'h503 + 4*k)), 4'hF);
    for (int i = 0; i < 36; i++) px(1'b0, 1'b1, 18'(18'h500 + i));
    tick();
    tick();
    chk("stall_overflow", 96'(overflow), 96'(1));
    chk("stall_head_addr", 96'(wr.wr_addr), 96'(0));
    chk("stall_queue_len", 96'(exp_q.size()), 96'(8));
    wr.wr_ready = 1'b1;
    drain();
    tick();
    chk("drained_valid", 96'(wr.wr_valid), 96'(0));
    chk("overflow_sticky", 96'(overflow), 96'(1));

    // Reset mid-frame discards the partial word and clears overflow
    px(1'b1, 1'b0, 18'd0);
    px(1'b0, 1'b1, 18'h600);
    px(1'b0, 1'b1, 18'h601);
    rst_n = 1'b0;
    #1;
    chk("midrst_overflow", 96'(overflow), 96'(0));
    chk("midrst_valid", 96'(wr.wr_valid), 96'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_valid", 96'(wr.wr_valid), 96'(0));
    px(1'b0, 1'b1, 18'h602);
    tick();
    chk("post_rst_ignore_we", 96'(wr.wr_valid), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
